// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86-64 encodings and stage-control decode
//
// Holds the status encodings, the INOP icode, the RNONE register ID and the
// stage_ctl_e action enum used by every pipeline stage register.
package y86_pkg;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    localparam logic [3:0] INOP  = 4'h1;
    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [1:0] {
        LOAD,
        HOLD,
        BUBBLE
    } stage_ctl_e;

    // Bubble outranks stall: a conflicting request must still flush the stage.
    function automatic stage_ctl_e decode_ctl(input logic stall, input logic bubble);
        if (bubble) begin
            return BUBBLE;
        end
        if (stall) begin
            return HOLD;
        end
        return LOAD;
    endfunction

endpackage

// File: rtl/y86_pipe_reg_if.sv
// rtl/y86_pipe_reg_if.sv - bundle of hazard controls, stage fields and status for y86_pipe_reg
//
// master: hazard unit / upstream stage side (drives controls and in_* fields)
// slave : the pipeline register (drives out_* fields, flags and counters)
interface y86_pipe_reg_if #(
    parameter int DATA_W     = 192,
    parameter int REG_FIELDS = 4
);
    logic                    stall;
    logic                    bubble;
    logic                    perf_clr;
    logic [1:0]              in_stat;
    logic [3:0]              in_icode;
    logic [3:0]              in_ifun;
    logic [DATA_W-1:0]       in_data;
    logic [REG_FIELDS*4-1:0] in_regs;
    logic [1:0]              out_stat;
    logic [3:0]              out_icode;
    logic [3:0]              out_ifun;
    logic [DATA_W-1:0]       out_data;
    logic [REG_FIELDS*4-1:0] out_regs;
    logic                    out_valid;
    logic                    ctl_err;
    logic                    stall_timeout;
    logic [31:0]             stall_cnt;
    logic [31:0]             bubble_cnt;

    modport master (
        output stall, bubble, perf_clr, in_stat, in_icode, in_ifun, in_data, in_regs,
        input  out_stat, out_icode, out_ifun, out_data, out_regs, out_valid,
               ctl_err, stall_timeout, stall_cnt, bubble_cnt
    );

    modport slave (
        input  stall, bubble, perf_clr, in_stat, in_icode, in_ifun, in_data, in_regs,
        output out_stat, out_icode, out_ifun, out_data, out_regs, out_valid,
               ctl_err, stall_timeout, stall_cnt, bubble_cnt
    );
endinterface

// File: rtl/y86_stall_watchdog.sv
// rtl/y86_stall_watchdog.sv - consecutive-stall counter with registered timeout flag
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   stall_only     : this edge is a hold (stall without bubble)
//   stall_timeout  : high while the consecutive-stall count equals MAX_STALL
module y86_stall_watchdog #(
    parameter int MAX_STALL = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stall_only,
    output logic stall_timeout
);

    localparam logic [7:0] LIMIT = 8'(MAX_STALL);

    logic [7:0] run_q;
    logic [7:0] run_d;

    // Saturate so a very long stall keeps the flag up instead of wrapping.
    always_comb begin
        run_d = 8'd0;
        if (stall_only) begin
            run_d = (run_q == LIMIT) ? run_q : run_q + 8'd1;
        end
    end

    // The flag is computed from the next count so it rises on the very edge
    // the limit is reached and falls on the edge the count clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q         <= 8'd0;
            stall_timeout <= 1'b0;
        end else begin
            run_q         <= run_d;
            stall_timeout <= (run_d == LIMIT);
        end
    end

endmodule

// File: rtl/y86_pipe_reg.sv
// rtl/y86_pipe_reg.sv - configurable Y86-64 pipeline stage register with stall/bubble control
//
// Ports:
//   clk, rst_n : stage clock, asynchronous active-low reset
//   bus        : y86_pipe_reg_if.slave - stall/bubble/perf_clr and in_* fields in;
//                out_* fields, out_valid, ctl_err, stall_timeout, stall_cnt,
//                bubble_cnt out (all register-driven)
// Optional feature macro: Y86_PIPE_PERF_EN enables the stall/bubble counters;
// without it both counters read 0 and perf_clr is ignored.
import y86_pkg::*;

module y86_pipe_reg #(
    parameter int         DATA_W       = 192,
    parameter int         REG_FIELDS   = 4,
    parameter int         MAX_STALL    = 15,
    parameter logic [3:0] BUBBLE_ICODE = INOP
) (
    input  logic         clk,
    input  logic         rst_n,
    y86_pipe_reg_if.slave bus
);

    localparam logic [REG_FIELDS*4-1:0] REGS_NONE = {REG_FIELDS{RNONE}};

    stage_ctl_e ctl;

    always_comb begin
        ctl = decode_ctl(bus.stall, bus.bubble);
    end

    // Field registers; HOLD leaves everything untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_stat  <= STAT_AOK;
            bus.out_icode <= BUBBLE_ICODE;
            bus.out_ifun  <= 4'h0;
            bus.out_data  <= '0;
            bus.out_regs  <= REGS_NONE;
            bus.out_valid <= 1'b0;
        end else begin
            case (ctl)
                BUBBLE: begin
                    bus.out_stat  <= STAT_AOK;
                    bus.out_icode <= BUBBLE_ICODE;
                    bus.out_ifun  <= 4'h0;
                    bus.out_data  <= '0;
                    bus.out_regs  <= REGS_NONE;
                    bus.out_valid <= 1'b0;
                end
                LOAD: begin
                    bus.out_stat  <= bus.in_stat;
                    bus.out_icode <= bus.in_icode;
                    bus.out_ifun  <= bus.in_ifun;
                    bus.out_data  <= bus.in_data;
                    bus.out_regs  <= bus.in_regs;
                    bus.out_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Sticky: a hazard unit asking for stall and bubble at once is a bug upstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ctl_err <= 1'b0;
        end else if (bus.stall && bus.bubble) begin
            bus.ctl_err <= 1'b1;
        end
    end

    y86_stall_watchdog #(
        .MAX_STALL (MAX_STALL)
    ) u_watchdog (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_only    (ctl == HOLD),
        .stall_timeout (bus.stall_timeout)
    );

`ifdef Y86_PIPE_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] bubble_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q  <= 32'd0;
            bubble_q <= 32'd0;
        end else if (bus.perf_clr) begin
            stall_q  <= 32'd0;
            bubble_q <= 32'd0;
        end else begin
            if (ctl == HOLD) begin
                stall_q <= stall_q + 32'd1;
            end
            if (ctl == BUBBLE) begin
                bubble_q <= bubble_q + 32'd1;
            end
        end
    end

    assign bus.stall_cnt  = stall_q;
    assign bus.bubble_cnt = bubble_q;
`else
    logic unused_perf_clr;

    assign unused_perf_clr = bus.perf_clr;
    assign bus.stall_cnt   = 32'd0;
    assign bus.bubble_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_y86_pipe_reg.sv
// tb/tb_y86_pipe_reg.sv - scoreboard bench for y86_pipe_reg with a behavioural stage model
module tb_y86_pipe_reg;

    localparam int DW   = 192;
    localparam int RF   = 4;
    localparam int MAXS = 4;

    typedef struct {
        logic [1:0]    stat;
        logic [3:0]    icode;
        logic [3:0]    ifun;
        logic [DW-1:0] data;
        logic [15:0]   regs;
        logic          valid;
        logic          err;
        logic          tmo;
        logic [31:0]   scnt;
        logic [31:0]   bcnt;
    } exp_t;

    logic clk;
    logic rst_n;

    y86_pipe_reg_if #(.DATA_W(DW), .REG_FIELDS(RF)) bus ();

    y86_pipe_reg #(
        .DATA_W       (DW),
        .REG_FIELDS   (RF),
        .MAX_STALL    (MAXS),
        .BUBBLE_ICODE (4'h1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    exp_t q[$];

    // Reference model state: what the stage should hold, in plain terms.
    exp_t        m;
    int          run_len;
    int unsigned m_scnt;
    int unsigned m_bcnt;

    function automatic void cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void check_all(input exp_t e);
        cmp("out_stat",      DW'(bus.out_stat),      DW'(e.stat));
        cmp("out_icode",     DW'(bus.out_icode),     DW'(e.icode));
        cmp("out_ifun",      DW'(bus.out_ifun),      DW'(e.ifun));
        cmp("out_data",      bus.out_data,           e.data);
        cmp("out_regs",      DW'(bus.out_regs),      DW'(e.regs));
        cmp("out_valid",     DW'(bus.out_valid),     DW'(e.valid));
        cmp("ctl_err",       DW'(bus.ctl_err),       DW'(e.err));
        cmp("stall_timeout", DW'(bus.stall_timeout), DW'(e.tmo));
        cmp("stall_cnt",     DW'(bus.stall_cnt),     DW'(e.scnt));
        cmp("bubble_cnt",    DW'(bus.bubble_cnt),    DW'(e.bcnt));
    endfunction

    function automatic exp_t reset_state();
        exp_t e;
        e.stat  = 2'd0;
        e.icode = 4'h1;
        e.ifun  = 4'h0;
        e.data  = '0;
        e.regs  = 16'hFFFF;
        e.valid = 1'b0;
        e.err   = 1'b0;
        e.tmo   = 1'b0;
        e.scnt  = 32'd0;
        e.bcnt  = 32'd0;
        return e;
    endfunction

    function automatic void model_reset();
        m       = reset_state();
        run_len = 0;
        m_scnt  = 0;
        m_bcnt  = 0;
    endfunction

    // Drive one cycle's inputs at the falling edge, advance the model to what
    // the next rising edge must produce and queue that for the monitor.
    task automatic step(input logic rn, input logic s, input logic b, input logic pc,
                        input logic [1:0] st, input logic [3:0] ic, input logic [3:0] fn,
                        input logic [DW-1:0] d, input logic [15:0] r);
        @(negedge clk);
        rst_n        = rn;
        bus.stall    = s;
        bus.bubble   = b;
        bus.perf_clr = pc;
        bus.in_stat  = st;
        bus.in_icode = ic;
        bus.in_ifun  = fn;
        bus.in_data  = d;
        bus.in_regs  = r;
        if (!rn) begin
            model_reset();
        end else begin
            if (b) begin
                m.stat  = 2'd0;
                m.icode = 4'h1;
                m.ifun  = 4'h0;
                m.data  = '0;
                m.regs  = 16'hFFFF;
                m.valid = 1'b0;
            end else if (!s) begin
                m.stat  = st;
                m.icode = ic;
                m.ifun  = fn;
                m.data  = d;
                m.regs  = r;
                m.valid = 1'b1;
            end
            if (s && b) m.err = 1'b1;
            run_len = (s && !b) ? run_len + 1 : 0;
            m.tmo   = (run_len >= MAXS);
`ifdef Y86_PIPE_PERF_EN
            if (pc) begin
                m_scnt = 0;
                m_bcnt = 0;
            end else begin
                if (s && !b) m_scnt = m_scnt + 1;
                if (b)       m_bcnt = m_bcnt + 1;
            end
`endif
            m.scnt = m_scnt;
            m.bcnt = m_bcnt;
        end
        q.push_back(m);
    endtask

    function automatic logic [DW-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic load(input logic [3:0] ic, input logic [15:0] r);
        step(1, 0, 0, 0, 2'($urandom_range(0, 3)), ic, 4'($urandom), rand_data(), r);
    endtask

    task automatic hold(input logic [3:0] ic);
        step(1, 1, 0, 0, 2'd0, ic, 4'h0, rand_data(), 16'($urandom));
    endtask

    task automatic random_steps(input int n, input bit allow_conflict);
        for (int i = 0; i < n; i++) begin
            logic s;
            logic b;
            logic pc;
            s  = ($urandom_range(0, 99) < 35);
            b  = ($urandom_range(0, 99) < 15);
            pc = ($urandom_range(0, 99) < 3);
            if (!allow_conflict && s) b = 1'b0;
            step(1, s, b, pc, 2'($urandom), 4'($urandom), 4'($urandom), rand_data(), 16'($urandom));
        end
    endtask

    // Monitor: every rising edge that has a queued expectation is checked
    // shortly after the edge, independently of the stimulus thread.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            check_all(q.pop_front());
        end
    end

    initial begin
        rst_n        = 1'b0;
        bus.stall    = 1'b0;
        bus.bubble   = 1'b0;
        bus.perf_clr = 1'b0;
        bus.in_stat  = 2'd0;
        bus.in_icode = 4'h0;
        bus.in_ifun  = 4'h0;
        bus.in_data  = '0;
        bus.in_regs  = '0;
        model_reset();

        // Reset, then release with icode 6 presented.
        step(0, 0, 0, 0, 2'd0, 4'h6, 4'h0, DW'(5), 16'h0123);
        step(0, 0, 0, 0, 2'd0, 4'h6, 4'h0, DW'(5), 16'h0123);
        step(1, 0, 0, 0, 2'd0, 4'h6, 4'h0, DW'(5), 16'h0123);

        // Stall hold while inputs change.
        load(4'h3, 16'h4567);
        repeat (3) hold(4'h5);

        // Bubble after a real instruction.
        load(4'h7, 16'h3210);
        step(1, 0, 1, 0, 2'd0, 4'h7, 4'h2, rand_data(), 16'h3210);

        // Watchdog: reach the limit, stay there, then clear.
        load(4'h2, 16'h1111);
        repeat (6) hold(4'h9);
        load(4'h4, 16'h2222);
        repeat (3) hold(4'h9);
        step(1, 1, 1, 0, 2'd0, 4'h9, 4'h0, '0, 16'h0);
        step(0, 0, 0, 0, 2'd0, 4'h0, 4'h0, '0, 16'h0);

        // Performance counters: 5 stalls, 2 bubbles, then clear during a stall.
        load(4'h6, 16'h0000);
        repeat (5) hold(4'h8);
        step(1, 0, 1, 0, 2'd0, 4'h8, 4'h0, '0, 16'h0);
        step(1, 0, 1, 0, 2'd0, 4'h8, 4'h0, '0, 16'h0);
        step(1, 1, 0, 1, 2'd0, 4'h8, 4'h0, '0, 16'h0);
        load(4'h5, 16'h5555);

        random_steps(300, 1'b0);

        // Conflict: sticky through ten ordinary loads.
        step(1, 1, 1, 0, 2'd1, 4'hA, 4'h3, rand_data(), 16'h7654);
        for (int i = 0; i < 10; i++) load(4'($urandom), 16'($urandom));

        // Asynchronous reset in the middle of a stall.
        load(4'hB, 16'hABCD);
        hold(4'hC);
        hold(4'hC);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all(m);
        step(0, 1, 0, 0, 2'd0, 4'hC, 4'h0, '0, 16'h0);
        step(1, 1, 0, 0, 2'd0, 4'hC, 4'h0, '0, 16'h0);
        load(4'h6, 16'h6666);

        random_steps(300, 1'b1);

        @(negedge clk);
        bus.stall = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/y86_pipe_reg.md
# y86_pipe_reg

Parametrised Y86-64 pipeline stage register that replaces the fixed per-stage latches (F/D, D/E, E/M, M/W) with one configurable block. It captures the upstream stage's control and data fields on each rising clock edge. It supports the PIPE hazard controls: stall holds the current contents, and bubble injects a NOP. It also provides a stall watchdog, a sticky control-conflict flag, and optional performance counters. One instance sits between each pair of adjacent stages; the hazard-control unit drives `stall` and `bubble`.

## Interface
Parameters:
- DATA_W, 192, width of the packed data payload (default valC/valA/valB, 3×64)
- REG_FIELDS, 4, number of 4-bit register-ID fields (default dstE, dstM, srcA, srcB; field 0 at the LSBs)
- MAX_STALL, 15, number of consecutive stalled edges before the watchdog fires; legal range 1..255
- BUBBLE_ICODE, 4'h1, icode loaded on bubble (INOP)

Ports:
- clk  in  1  stage clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hold the current contents
- bubble  in  1  load the NOP bubble
- in_stat  in  2  upstream status (0 AOK, 1 HLT, 2 ADR, 3 INS)
- in_icode  in  4  upstream icode
- in_ifun  in  4  upstream ifun
- in_data  in  DATA_W  upstream payload
- in_regs  in  REG_FIELDS*4  upstream register IDs
- out_stat / out_icode / out_ifun / out_data / out_regs  out  same widths as inputs  registered fields
- out_valid  out  1  high when the register holds a real instruction, not a bubble or reset value
- ctl_err  out  1  sticky: `stall` and `bubble` were asserted together
- stall_timeout  out  1  consecutive stall count has reached MAX_STALL
- perf_clr  in  1  synchronous clear of the performance counters
- stall_cnt  out  32  total stalled cycles
- bubble_cnt  out  32  total bubble cycles

## Operation
- Reset value (rst_n=0, asynchronous) is the bubble state for every output:
  - out_stat=0, out_icode=BUBBLE_ICODE, out_ifun=0, out_data=0, every out_regs field=4'hF (RNONE).
  - out_valid=0, ctl_err=0, stall_timeout=0, stall counter=0, stall_cnt=0, bubble_cnt=0.
- Each edge selects one action, in this priority order:
  - bubble=1: load the bubble state; out_valid←0.
  - stall=1 (bubble=0): all fields and out_valid hold.
  - otherwise: load all in_* fields; out_valid←1.
- Bubble and stall together: bubble wins, and ctl_err←1. ctl_err clears only on reset.
- Consecutive-stall counter (8-bit, saturating at MAX_STALL):
  - increments on each edge with stall=1 and bubble=0;
  - clears to 0 on any other edge.
- stall_timeout is registered high while the counter equals MAX_STALL. It drops on the first edge the counter clears.
- Reset asserted mid-stall or mid-bubble forces the reset values immediately. The first edge after deassertion follows the normal rules.

## Timing
- Latency: one cycle from in_* to out_*; no combinational input-to-output path.
- stall, bubble and perf_clr are sampled only on the rising edge.
- With MAX_STALL=N and stall held continuously from edge 1, stall_timeout is high after edge N.
- All outputs are register-driven.

## Configuration
- Y86_PIPE_PERF_EN defined:
  - stall_cnt increments on stall-only edges; bubble_cnt increments on edges with bubble=1.
  - Both counters wrap at 2^32.
  - perf_clr=1 zeroes both counters on that edge and takes priority over increment.
- Y86_PIPE_PERF_EN undefined:
  - stall_cnt and bubble_cnt are constant 0 and perf_clr is ignored.
  - No counter flops are synthesised.

## Structure
- Shared package y86_pkg holds:
  - stat encodings STAT_AOK/HLT/ADR/INS, INOP=4'h1, RNONE=4'hF;
  - a stage_ctl_e enum (LOAD, HOLD, BUBBLE).
- One sub-module, y86_stall_watchdog: the consecutive-stall counter and stall_timeout, instantiated once.
- The top-level block contains the action decode, field registers and the optional performance counters.

## Test plan
- Reset and load:
  - During and after rst_n=0, outputs read icode=1, regs=0xFFFF, out_valid=0.
  - Drive icode=6, ifun=0, data=0x…05, then release reset: one edge later out_icode=6, out_valid=1.
- Stall hold: load icode=3, then stall=1 for 3 edges while the inputs change to icode=5 → outputs remain icode=3 for all 3 cycles.
- Bubble: load icode=7 with regs=0x3210, then bubble=1 → next edge icode=1, ifun=0, regs=0xFFFF, out_valid=0.
- Conflict: stall=1 and bubble=1 on the same edge → bubble state loaded and ctl_err=1; ctl_err stays 1 through 10 further normal cycles until reset.
- Watchdog with MAX_STALL=4:
  - 4 consecutive stall edges → stall_timeout=1 after edge 4.
  - stall held for 2 more edges → still 1.
  - stall=0 → 0 after the next edge.
- Perf counters with Y86_PIPE_PERF_EN defined: 5 stall edges and 2 bubble edges → stall_cnt=5, bubble_cnt=2; perf_clr=1 with stall=1 → both counters 0.
